branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_if.sv | 32 +++
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Bundle of EX-stage resolve inputs, IF-stage lookup, and redirect/stat outputs.
// master drives the pipeline side; slave is the branch resolve unit.
interface branch_resolve_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_is_branch;
  logic [2:0]      ex_func3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output ex_valid, ex_is_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target,
           ex_pred_taken, if_pc,
    input  if_pred_taken, flush, redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_target,
           ex_pred_taken, if_pc,
    output if_pred_taken, flush, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: condition compare, 2-bit BHT predictor, mispredict flush/redirect.
// Optional performance counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input logic              clk,
  input logic              rst,
  branch_resolve_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  if ((BHT_ENTRIES < 2) || ((BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0)) begin : g_bad_depth
    $error("BHT_ENTRIES must be a power of 2 and at least 2");
  end

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];
  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;

  logic             resolve;
  logic             legal;
  logic             taken;
  logic             mispredict;
  logic             update;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign if_idx = bus.if_pc[IDX_W+1:2];

  // The instruction in EX during a flush cycle is wrong-path.
  assign resolve = bus.ex_valid && bus.ex_is_branch && !flush_q;
  assign legal   = (bus.ex_func3[2:1] != 2'b01);

  always_comb begin
    taken = 1'b0;
    case (bus.ex_func3)
      3'b000:  taken = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  taken = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  taken = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign update     = resolve && legal;
  assign mispredict = update && (taken != bus.ex_pred_taken);

  always_comb begin
    flush_d    = mispredict;
    redirect_d = redirect_q;
    if (mispredict) begin
      redirect_d = taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
      bht_d[i] = bht_q[i];
    end
    if (update) begin
      if (taken && (bht_q[ex_idx] != 2'b11)) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!taken && (bht_q[ex_idx] != 2'b00)) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= bht_d[i];
      end
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign bus.if_pred_taken = bht_q[if_idx][1];
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (update && (stat_br_q != 32'hFFFF_FFFF)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

  // Only the index bits of the PCs feed the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.ex_pc, bus.if_pc};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue scoreboard of expected flush/redirect.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NENT = 16;

  logic clk = 1'b0;
  logic rst;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (NENT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [1:0]  m_bht[NENT];
  logic        m_flush;
  logic        m_flush_nxt;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NENT); i++) m_bht[i] = 2'b01;
    m_flush     = 1'b0;
    m_flush_nxt = 1'b0;
    m_redir     = '0;
    m_br        = '0;
    m_mp        = '0;
    sb.delete();
  endtask

  // Drive one EX slot and push what the DUT must show after the next edge.
  task automatic present(input string tag, input logic v, input logic isbr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    logic res, legal, tk, misp;
    logic [31:0] r;
    int k;
    bus.ex_valid      = v;
    bus.ex_is_branch  = isbr;
    bus.ex_func3      = f3;
    bus.ex_rs1        = a;
    bus.ex_rs2        = b;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.ex_pred_taken = pred;
    #1;
    chk({tag, "/lookup_pre"}, 32'(bus.if_pred_taken), 32'(m_bht[idx(bus.if_pc)][1]));
    res   = v && isbr && !m_flush;
    legal = (f3[2:1] != 2'b01);
    tk    = legal && ref_taken(f3, a, b);
    misp  = res && legal && (tk != pred);
    r     = misp ? (tk ? tgt : pc + 32'd4) : m_redir;
    sb.push_back('{tag, misp, r});
    m_redir     = r;
    m_flush_nxt = misp;
    if (res && legal) begin
      k = idx(pc);
      if (tk && m_bht[k] != 2'b11) m_bht[k] = m_bht[k] + 2'b01;
      else if (!tk && m_bht[k] != 2'b00) m_bht[k] = m_bht[k] - 2'b01;
`ifdef BRANCH_STATS_EN
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
      if (misp && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
`endif
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    m_flush = m_flush_nxt;
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "/flush"}, 32'(bus.flush), 32'(e.flush));
      chk({e.tag, "/redirect"}, bus.redirect_pc, e.redir);
    end
    chk("stat_branches", bus.stat_branches, m_br);
    chk("stat_mispredicts", bus.stat_mispredicts, m_mp);
    chk("lookup_post", 32'(bus.if_pred_taken), 32'(m_bht[idx(bus.if_pc)][1]));
  endtask

  task automatic br(input string tag, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pred);
    present(tag, 1'b1, 1'b1, f3, a, b, pc, tgt, pred);
    tick();
  endtask

  task automatic idle(input string tag);
    present(tag, 1'b0, 1'b0, 3'b000, '0, '0, '0, '0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_func3 = '0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_pc = '0; bus.ex_target = '0;
    bus.ex_pred_taken = 1'b0; bus.if_pc = 32'h40;
    model_reset();
    #12;
    chk("reset_flush", 32'(bus.flush), 32'd0);
    chk("reset_redirect", bus.redirect_pc, 32'd0);
    chk("reset_pred_0x40", 32'(bus.if_pred_taken), 32'd0);
    chk("reset_stat_br", bus.stat_branches, 32'd0);
    chk("reset_stat_mp", bus.stat_mispredicts, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    br("beq_taken", 3'b000, 32'd5, 32'd5, 32'h40, 32'h80, 1'b0);
    chk("beq_flush", 32'(bus.flush), 32'd1);
    chk("beq_redirect", bus.redirect_pc, 32'h80);
    chk("bht_0x40_weak_taken", 32'(bus.if_pred_taken), 32'd1);
    idle("post_beq");

    br("blt_signed", 3'b100, 32'h8000_0000, 32'd1, 32'h104, 32'h300, 1'b0);
    idle("post_blt");
    br("bltu_unsigned", 3'b110, 32'h8000_0000, 32'd1, 32'h108, 32'h300, 1'b1);
    chk("bltu_redirect_pc4", bus.redirect_pc, 32'h10C);
    idle("post_bltu");
    br("bge_ovf", 3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h110, 32'h400, 1'b0);
    idle("post_bge");
    br("bgeu", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h114, 32'h400, 1'b1);
    idle("post_bgeu");
    br("bne_nt", 3'b001, 32'd3, 32'd3, 32'h118, 32'h500, 1'b1);
    idle("post_bne");
    br("pc4_wrap", 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10, 1'b1);
    chk("wrap_redirect", bus.redirect_pc, 32'h0);
    idle("post_wrap");

    bus.if_pc = 32'h20C;
    br("b2b_n", 3'b001, 32'd1, 32'd2, 32'h208, 32'h600, 1'b0);
    br("b2b_n1_ignored", 3'b000, 32'd7, 32'd7, 32'h20C, 32'h700, 1'b0);
    chk("b2b_n1_no_flush", 32'(bus.flush), 32'd0);
    chk("b2b_n1_no_update", 32'(bus.if_pred_taken), 32'd0);
    br("b2b_n2", 3'b000, 32'd7, 32'd7, 32'h20C, 32'h700, 1'b0);
    chk("b2b_n3_flush", 32'(bus.flush), 32'd1);
    idle("post_b2b");

    bus.if_pc = 32'h30;
    for (int i = 0; i < 5; i++) begin
      br($sformatf("sat_taken%0d", i), 3'b000, 32'd9, 32'd9, 32'h30, 32'h900, 1'b1);
    end
    chk("sat_pred", 32'(bus.if_pred_taken), 32'd1);
    br("sat_nt1", 3'b000, 32'd9, 32'd8, 32'h30, 32'h900, 1'b1);
    chk("sat_nt1_still_taken", 32'(bus.if_pred_taken), 32'd1);
    idle("post_nt1");
    br("sat_nt2", 3'b000, 32'd9, 32'd8, 32'h30, 32'h900, 1'b1);
    chk("sat_nt2_not_taken", 32'(bus.if_pred_taken), 32'd0);
    idle("post_nt2");

    br("f3_010", 3'b010, 32'd1, 32'd1, 32'h30, 32'h900, 1'b1);
    chk("f3_010_no_flush", 32'(bus.flush), 32'd0);
    br("f3_011", 3'b011, 32'd1, 32'd2, 32'h30, 32'h900, 1'b0);
    chk("f3_011_no_change", 32'(bus.if_pred_taken), 32'd0);

    bus.if_pc = 32'h40;
    br("pre_rst", 3'b000, 32'd1, 32'd1, 32'h40, 32'h88, 1'b0);
    chk("pre_rst_flush", 32'(bus.flush), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_flush", 32'(bus.flush), 32'd0);
    chk("rst_redirect", bus.redirect_pc, 32'd0);
    chk("rst_bht", 32'(bus.if_pred_taken), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
